// File: rtl/apb_completer.sv
// APB completer: a small register file with a read-only ID word, a privileged top
// register, programmable wait states and slave-error reporting on pslverr.
module apb_completer #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter int                    WAIT_STATES = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [2:0]              pprot,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);
   localparam int IW = $clog2(NUM_REGS);
   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [3:0]            wait_cnt, wait_cnt_n;
   logic                  pready_n;
   logic                  capture, commit, setup_req;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic                  cap_write, cap_priv;
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [SW-1:0]         cap_strb;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [IW-1:0]         idx;
   logic                  dec_err, wr_err, rd_err, err;
   logic                  unused_prot;

   assign unused_prot = ^pprot[2:1];
   assign setup_req   = psel & ~penable;

   // Errors are evaluated on the captured request, so they are stable for the whole transfer.
   assign idx     = cap_addr[IW+1:2];
   assign dec_err = (cap_addr[1:0] != 2'b00) | (|cap_addr[ADDR_WIDTH-1:IW+2]);
   assign wr_err  = cap_write & ((idx == '0) | ((idx == IW'(NUM_REGS-1)) & ~cap_priv));
   assign rd_err  = ~cap_write & (cap_strb != '0);
   assign err     = dec_err | wr_err | rd_err;

   assign pslverr = pready & err;
   assign prdata  = (pready & ~cap_write & ~err) ? ((idx == '0) ? ID_VALUE : regs[idx]) : '0;

   // SETUP covers the first penable cycle, so a zero-wait completion can finish there.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      pready_n   = 1'b0;
      capture    = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (setup_req) begin
               state_n    = SETUP;
               capture    = 1'b1;
               wait_cnt_n = '0;
               pready_n   = (WAIT_STATES == 0);
            end
         end
         SETUP, ACCESS: begin
            if (pready) begin
               commit = cap_write & ~err;
               if (setup_req) begin
                  state_n    = SETUP;
                  capture    = 1'b1;
                  wait_cnt_n = '0;
                  pready_n   = (WAIT_STATES == 0);
               end else begin
                  state_n = IDLE;
               end
            end else if (!psel) begin
               state_n = IDLE;
            end else if (state == SETUP) begin
               state_n    = ACCESS;
               wait_cnt_n = '0;
               pready_n   = (WAIT_STATES == 1);
            end else begin
               wait_cnt_n = wait_cnt + 4'd1;
               pready_n   = ((int'(wait_cnt) + 2) == WAIT_STATES);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         pready    <= 1'b0;
         cap_addr  <= '0;
         cap_write <= 1'b0;
         cap_priv  <= 1'b0;
         cap_wdata <= '0;
         cap_strb  <= '0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         pready   <= pready_n;
         if (capture) begin
            cap_addr  <= paddr;
            cap_write <= pwrite;
            cap_priv  <= pprot[0];
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit) begin
         for (int k = 0; k < SW; k++) begin
            if (cap_strb[k]) regs[idx][8*k +: 8] <= cap_wdata[8*k +: 8];
         end
      end
   end
endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: a zero-wait and a three-wait instance share one bus,
// selected by tgt; responses are checked against a reference register model.
module tb_apb_completer;
   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        pclk = 1'b0;
   logic        preset;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        tgt;
   logic        psel0, psel3;
   logic        pready0, pready3, pslverr0, pslverr3;
   logic [31:0] prdata0, prdata3;
   logic        pready_m, pslverr_m;
   logic [31:0] prdata_m;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_pready_cyc;
   logic [32:0] exp_q[$];
   logic [31:0] mdl [2][16];

   assign psel0     = psel & ~tgt;
   assign psel3     = psel & tgt;
   assign pready_m  = tgt ? pready3 : pready0;
   assign pslverr_m = tgt ? pslverr3 : pslverr0;
   assign prdata_m  = tgt ? prdata3 : prdata0;

   apb_completer #(.WAIT_STATES(0)) dut0 (
      .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot), .psel(psel0),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));

   apb_completer #(.WAIT_STATES(3)) dut3 (
      .pclk(pclk), .preset(preset), .paddr(paddr), .pprot(pprot), .psel(psel3),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready3), .prdata(prdata3), .pslverr(pslverr3));

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int t = 0; t < 2; t++)
         for (int i = 0; i < 16; i++) mdl[t][i] = '0;
   endfunction

   // Returns {pslverr, prdata} expected for the transfer and applies legal writes.
   function automatic logic [32:0] model_xfer(input logic wr, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] strb,
                                              input logic [2:0] prot);
      logic [3:0]  idx;
      logic        err;
      logic [31:0] rd;
      int          t;
      t   = tgt ? 1 : 0;
      idx = addr[5:2];
      err = (addr[1:0] != 2'b00) || (addr >= 32'h40) ||
            (wr && (idx == 4'd0 || (idx == 4'd15 && !prot[0]))) || (!wr && strb != 4'b0000);
      rd  = '0;
      if (!err && !wr) rd = (idx == 4'd0) ? ID : mdl[t][idx];
      if (!err && wr)
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[t][idx][8*b +: 8] = wdata[8*b +: 8];
      return {err, rd};
   endfunction

   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input bit to_idle,
                       input string name);
      int          k;
      int          ws;
      bit          done;
      logic [32:0] exp, got;
      ws = tgt ? 3 : 0;
      exp_q.push_back(model_xfer(wr, addr, wdata, strb, prot));
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
      pwdata = wdata; pstrb = strb; pprot = prot;
      @(negedge pclk);
      checks++;
      if (pready_m !== 1'b0) begin
         failures++;
         $display("FAIL %s pready_in_setup got=%b exp=0", name, pready_m);
      end
      @(posedge pclk); #1;
      penable = 1'b1;
      k = 0;
      done = 1'b0;
      while (!done && k < 32) begin
         @(negedge pclk);
         k++;
         got = {pslverr_m, prdata_m};
         if (pready_m === 1'b1) begin
            done = 1'b1;
            last_pready_cyc = cyc;
            checks++;
            if (k != ws + 1) begin
               failures++;
               $display("FAIL %s pready_cycle got=%0d exp=%0d", name, k, ws + 1);
            end
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL %s response got err=%b data=%h exp err=%b data=%h",
                        name, got[32], got[31:0], exp[32], exp[31:0]);
            end
         end else begin
            checks++;
            if (got !== 33'd0) begin
               failures++;
               $display("FAIL %s idle_outputs got err=%b data=%h exp 0", name, got[32], got[31:0]);
            end
         end
         @(posedge pclk); #1;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s pready_timeout got=none exp=cycle %0d", name, ws + 1);
         exp = exp_q.pop_front();
      end
      penable = 1'b0;
      if (to_idle) begin
         psel = 1'b0;
         @(negedge pclk);
         checks++;
         if (pready_m !== 1'b0) begin
            failures++;
            $display("FAIL %s pready_after got=%b exp=0", name, pready_m);
         end
         @(posedge pclk); #1;
      end
   endtask

   task automatic expect_quiet(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         checks++;
         if (pready0 !== 1'b0 || pready3 !== 1'b0) begin
            failures++;
            $display("FAIL %s pready got=%b%b exp=00", name, pready0, pready3);
         end
         @(posedge pclk); #1;
      end
   endtask

   task automatic test_reset();
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pwdata = '0; pstrb = '0; pprot = '0; tgt = 1'b0;
      model_reset();
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      checks++;
      if (pready0 !== 1'b0 || pready3 !== 1'b0) begin
         failures++; $display("FAIL reset_pready got=%b%b exp=00", pready0, pready3);
      end
      checks++;
      if (pslverr0 !== 1'b0 || pslverr3 !== 1'b0) begin
         failures++; $display("FAIL reset_pslverr got=%b%b exp=00", pslverr0, pslverr3);
      end
      checks++;
      if (prdata0 !== 32'd0 || prdata3 !== 32'd0) begin
         failures++; $display("FAIL reset_prdata got=%h/%h exp=0", prdata0, prdata3);
      end
      @(posedge pclk); #1;
      preset = 1'b0;
      expect_quiet(2, "reset_release");
   endtask

   task automatic test_id_read();
      tgt = 1'b0;
      xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, "id_read");
      tgt = 1'b1;
      xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, "id_read_ws3");
   endtask

   task automatic test_strobe_write();
      tgt = 1'b0;
      xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0101, 3'b000, 1'b1, "strb_write");
      xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b1, "strb_read");
      xfer(1'b1, 32'h4, 32'h1111_2222, 4'b0000, 3'b000, 1'b1, "strb_noop_write");
      xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b1, "strb_noop_read");
   endtask

   task automatic test_wait_states();
      tgt = 1'b1;
      xfer(1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b1, "ws3_write");
      xfer(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 1'b1, "ws3_read");
   endtask

   task automatic test_errors();
      tgt = 1'b0;
      xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b001, 1'b1, "err_write_id");
      xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 1'b1, "err_read_range");
      xfer(1'b0, 32'h6, 32'h0, 4'h0, 3'b000, 1'b1, "err_read_unaligned");
      xfer(1'b1, 32'h3C, 32'h0BAD_0BAD, 4'hF, 3'b000, 1'b1, "err_write_unpriv");
      xfer(1'b0, 32'h4, 32'h0, 4'hF, 3'b000, 1'b1, "err_read_strb");
      xfer(1'b1, 32'h44, 32'h7777_7777, 4'hF, 3'b001, 1'b1, "err_write_alias");
      xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, "err_check_id");
      xfer(1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 1'b1, "err_check_top");
      xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b1, "err_check_r1");
      xfer(1'b1, 32'h3C, 32'h1234_5678, 4'hF, 3'b001, 1'b1, "priv_write_top");
      xfer(1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 1'b1, "priv_read_top");
      for (int i = 0; i < 4; i++)
         xfer(1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0, 4'h0, 3'b000, 1'b1, "rand_read");
   endtask

   task automatic test_abort();
      tgt = 1'b1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
      pwdata = 32'hABCD_EF01; pstrb = 4'hF; pprot = 3'b001;
      @(posedge pclk); #1;
      penable = 1'b1;
      expect_quiet(1, "abort_wait");
      psel = 1'b0; penable = 1'b0;
      expect_quiet(5, "abort_after");
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b1, "abort_readback");
   endtask

   task automatic test_reset_mid();
      tgt = 1'b1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
      pwdata = 32'h5555_AAAA; pstrb = 4'hF; pprot = 3'b001;
      @(posedge pclk); #1;
      penable = 1'b1;
      expect_quiet(2, "rst_mid_wait");
      preset = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b0;
      model_reset();
      expect_quiet(4, "rst_mid_ignore");
      psel = 1'b0; penable = 1'b0;
      xfer(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 1'b1, "rst_mid_read");
   endtask

   task automatic test_back_to_back();
      int c1;
      tgt = 1'b0;
      xfer(1'b1, 32'hC, 32'h0000_1234, 4'hF, 3'b001, 1'b0, "b2b_write");
      c1 = last_pready_cyc;
      xfer(1'b0, 32'hC, 32'h0, 4'h0, 3'b001, 1'b0, "b2b_read");
      checks++;
      if (last_pready_cyc - c1 != 2) begin
         failures++; $display("FAIL b2b_gap1 got=%0d exp=2", last_pready_cyc - c1);
      end
      c1 = last_pready_cyc;
      xfer(1'b1, 32'h10, 32'h0000_FFFF, 4'hF, 3'b001, 1'b1, "b2b_write2");
      checks++;
      if (last_pready_cyc - c1 != 2) begin
         failures++; $display("FAIL b2b_gap2 got=%0d exp=2", last_pready_cyc - c1);
      end
      xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b1, "b2b_readback");
   endtask

   initial begin
      test_reset();
      test_id_read();
      test_strobe_write();
      test_wait_states();
      test_errors();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named pclk and preset; the polarity and synchronicity are fixed.
REQ-002 The block SHALL have these parameters:
  - DATA_WIDTH, default 32, data bus width.
  - ADDR_WIDTH, default 32, address bus width.
  - NUM_REGS, default 16, register count (power of 2).
  - WAIT_STATES, default 0, added access cycles (0..15).
  - ID_VALUE, default 32'hA5B0_0001, register 0 content.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  - pclk, in, 1, clock.
  - preset, in, 1, sync active-high reset.
  - paddr, in, ADDR_WIDTH, byte address.
  - pprot, in, 3, protection type.
  - psel, in, 1, completer select.
  - penable, in, 1, access phase.
  - pwrite, in, 1, 1=write, 0=read.
  - pwdata, in, DATA_WIDTH, write data.
  - pstrb, in, DATA_WIDTH/8, write byte strobes.
  - pready, out, 1, transfer complete.
  - prdata, out, DATA_WIDTH, read data.
  - pslverr, out, 1, transfer error.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS and SHALL update only on the rising edge of pclk.
REQ-005 IDLE->SETUP on psel=1 & penable=0; psel=1 & penable=1 seen in IDLE SHALL be ignored (no state change, no response).
REQ-006 SETUP->ACCESS unconditionally; the address, direction, data, strobes and pprot SHALL be captured at the SETUP-entry edge.
REQ-007 In ACCESS, a wait counter SHALL count from 0; pready SHALL be registered and high during access-phase cycle WAIT_STATES+1 (WAIT_STATES=0: pready high in the first penable cycle).
REQ-008 pready SHALL be high for exactly one cycle per transfer, then ACCESS->SETUP if psel=1 & penable=0, else ACCESS->IDLE.
REQ-009 If psel=0 during ACCESS before pready, the transfer SHALL abort: go to IDLE, no register write, pready/pslverr stay 0.
REQ-010 Decode: index = paddr[log2(NUM_REGS)+1:2]; a decode error occurs when paddr[1:0]!=0 or paddr >= 4*NUM_REGS.
REQ-011 A write error occurs on a write to register 0 (read-only ID), or a write to register NUM_REGS-1 with pprot[0]=0 (privileged-only).
REQ-012 A read error occurs when pstrb != 0 on a read.
REQ-013 pslverr SHALL equal the OR of the decode, write and read error conditions, and SHALL be valid only while pready=1, otherwise 0.
REQ-014 A write SHALL commit at the edge ending the pready cycle, only when there is no error: byte lane k is written iff pstrb[k]=1; pstrb=0 is a legal no-op write.
REQ-015 A read SHALL drive prdata = reg[index] (register 0 = ID_VALUE) during the pready cycle; prdata SHALL be 0 at all other times and on erroring reads.
REQ-016 Back-to-back transfers (pready cycle followed directly by SETUP) SHALL be supported with no idle cycle.
REQ-017 A read of a register written by the immediately preceding transfer SHALL return the new value.

Reset
REQ-018 While preset=1 at a clock edge, the block SHALL set state=IDLE, wait counter=0, pready=0, pslverr=0, prdata=0 and registers 1..NUM_REGS-1 = 0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no register write; the first transfer after reset release SHALL start from IDLE.

Verification
REQ-020 Reset then read addr 0x0, WAIT_STATES=0 -> pready in first access cycle, prdata=0xA5B00001, pslverr=0.
REQ-021 Write 0xDEADBEEF to 0x4 with pstrb=4'b0101, then read 0x4 -> prdata=0x00AD00EF, pslverr=0.
REQ-022 WAIT_STATES=3, write to 0x8 -> pready high in the 4th penable cycle only, for exactly one cycle.
REQ-023 Illegal accesses, each -> pslverr=1 with pready, no register change:
  - write to 0x0
  - read of 0x40 (NUM_REGS=16)
  - read of 0x6
  - write to 0x3C with pprot=3'b000
  - read with pstrb=4'b1111
REQ-024 Write to 0x8 with preset pulsed during the ACCESS wait, then read 0x8 -> prdata=0, no pready from the aborted transfer.
REQ-025 Three back-to-back transfers (write 0xC=0x1234, read 0xC, write 0x10=0xFFFF) with psel held high -> no idle cycles, the read returns 0x00001234, three single-cycle pready pulses.
